sat_chan_sched: RTL and testbench

SAT_CHAN_SCHED -- requirements
Module: sat_chan_sched

---
 rtl/sat_chan_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_sat_chan_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_chan_sched.sv
// rtl/sat_chan_sched.sv - epoch-aligned configuration scheduler for sat_chan instances
//
// Purpose:
//   Collects per-channel configuration writes into shadow registers and copies
//   all shadows to the active outputs together at the next epoch boundary
//   after a commit. This keeps every channel retuning on the same epoch.
//
// Optional feature (macro SAT_CHAN_SCHED_FREQ_RAMP_EN):
//   Adds a signed per-channel rate. On each epoch boundary that is not an
//   apply, the rate is added to the active freq of every enabled channel,
//   wrapping modulo 2^32. Without the macro, field 3 is accepted and dropped.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   cfg_valid    in   config write request
//   cfg_ready    out  config write accept (low while an apply is imminent)
//   cfg_chan     in   target channel
//   cfg_field    in   0=freq 1=gain 2=enable 3=rate 4=commit 5..7 reserved
//   cfg_data     in   write data (gain uses [15:0], enable uses [0])
//   chan_enable  out  active enable per channel
//   chan_freq    out  active freq, channel i at [32i+31:32i]
//   chan_gain    out  active gain, channel i at [16i+15:16i]
//   epoch        out  one-cycle pulse per epoch
//   armed        out  commit pending
//   commit_done  out  one-cycle pulse when new active values appear

module sat_chan_sched #(
  parameter int NCHAN     = 4,
  parameter int EPOCH_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(NCHAN)-1:0] cfg_chan,
  input  logic [2:0]               cfg_field,
  input  logic [31:0]              cfg_data,
  output logic [NCHAN-1:0]         chan_enable,
  output logic [NCHAN*32-1:0]      chan_freq,
  output logic [NCHAN*16-1:0]      chan_gain,
  output logic                     epoch,
  output logic                     armed,
  output logic                     commit_done
);

  localparam int SW = $clog2(NCHAN);
  localparam int CW = $clog2(EPOCH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(EPOCH_DIV - 1);

  localparam logic [2:0] F_FREQ   = 3'd0;
  localparam logic [2:0] F_GAIN   = 3'd1;
  localparam logic [2:0] F_ENABLE = 3'd2;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
  localparam logic [2:0] F_RATE   = 3'd3;
`endif
  localparam logic [2:0] F_COMMIT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  state_e state_q;
  logic   armed_q;
  logic   done_q;
  logic   epoch_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          epoch_tick;
  logic          cfg_fire;

  logic [NCHAN*32-1:0] sh_freq_q, sh_freq_d;
  logic [NCHAN*16-1:0] sh_gain_q, sh_gain_d;
  logic [NCHAN-1:0]    sh_en_q, sh_en_d;
  logic [NCHAN*32-1:0] act_freq_q, act_freq_d;
  logic [NCHAN*16-1:0] act_gain_q, act_gain_d;
  logic [NCHAN-1:0]    act_en_q, act_en_d;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
  logic [NCHAN*32-1:0] sh_rate_q, sh_rate_d;
  logic [NCHAN*32-1:0] act_rate_q, act_rate_d;
`endif

  // Free-running epoch counter, independent of the FSM.
  assign epoch_tick = (cnt_q == CNT_LAST);
  assign cnt_d      = epoch_tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Writes are refused while the shadows are about to be (or are being)
  // copied, so a shadow update can never land half-in an apply.
  assign cfg_ready = !((state_q == S_APPLY) || ((state_q == S_ARMED) && epoch_tick));
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Shadow register updates; cfg_chan values beyond NCHAN-1 match nothing.
  always_comb begin
    sh_freq_d = sh_freq_q;
    sh_gain_d = sh_gain_q;
    sh_en_d   = sh_en_q;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
    sh_rate_d = sh_rate_q;
`endif
    if (cfg_fire) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (cfg_chan == SW'(i)) begin
          case (cfg_field)
            F_FREQ:   sh_freq_d[i*32 +: 32] = cfg_data;
            F_GAIN:   sh_gain_d[i*16 +: 16] = cfg_data[15:0];
            F_ENABLE: sh_en_d[i]            = cfg_data[0];
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
            F_RATE:   sh_rate_d[i*32 +: 32] = cfg_data;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Active registers: bulk copy in APPLY, otherwise optional per-epoch ramp.
  // The epoch that moves ARMED to APPLY is skipped by the ramp so the apply
  // epoch shows the raw shadow values.
  always_comb begin
    act_freq_d = act_freq_q;
    act_gain_d = act_gain_q;
    act_en_d   = act_en_q;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
    act_rate_d = act_rate_q;
`endif
    if (state_q == S_APPLY) begin
      act_freq_d = sh_freq_q;
      act_gain_d = sh_gain_q;
      act_en_d   = sh_en_q;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
      act_rate_d = sh_rate_q;
`endif
    end
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
    else if (epoch_tick && (state_q != S_ARMED)) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (act_en_q[i]) begin
          act_freq_d[i*32 +: 32] = act_freq_q[i*32 +: 32] + act_rate_q[i*32 +: 32];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_freq_q  <= '0;
      sh_gain_q  <= '0;
      sh_en_q    <= '0;
      act_freq_q <= '0;
      act_gain_q <= '0;
      act_en_q   <= '0;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
      sh_rate_q  <= '0;
      act_rate_q <= '0;
`endif
    end else begin
      sh_freq_q  <= sh_freq_d;
      sh_gain_q  <= sh_gain_d;
      sh_en_q    <= sh_en_d;
      act_freq_q <= act_freq_d;
      act_gain_q <= act_gain_d;
      act_en_q   <= act_en_d;
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
      sh_rate_q  <= sh_rate_d;
      act_rate_q <= act_rate_d;
`endif
    end
  end

  // Commit FSM. A commit seen in IDLE on a tick cycle arms here, and the
  // tick it arrived with is already gone, so it applies one epoch later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      epoch_q <= 1'b0;
    end else begin
      epoch_q <= epoch_tick;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_fire && (cfg_field == F_COMMIT)) begin
            state_q <= S_ARMED;
            armed_q <= 1'b1;
          end
        end
        S_ARMED: begin
          if (epoch_tick) begin
            state_q <= S_APPLY;
            armed_q <= 1'b0;
          end
        end
        S_APPLY: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign chan_enable = act_en_q;
  assign chan_freq   = act_freq_q;
  assign chan_gain   = act_gain_q;
  assign epoch       = epoch_q;
  assign armed       = armed_q;
  assign commit_done = done_q;

endmodule

// File: tb/tb_sat_chan_sched.sv
// tb/tb_sat_chan_sched.sv - self-checking bench for sat_chan_sched
module tb_sat_chan_sched;

  localparam int NCHAN     = 4;
  localparam int EPOCH_DIV = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_chan;
  logic [2:0]   cfg_field;
  logic [31:0]  cfg_data;
  logic [3:0]   chan_enable;
  logic [127:0] chan_freq;
  logic [63:0]  chan_gain;
  logic         epoch;
  logic         armed;
  logic         commit_done;

  sat_chan_sched #(.NCHAN(NCHAN), .EPOCH_DIV(EPOCH_DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_field   (cfg_field),
    .cfg_data    (cfg_data),
    .chan_enable (chan_enable),
    .chan_freq   (chan_freq),
    .chan_gain   (chan_gain),
    .epoch       (epoch),
    .armed       (armed),
    .commit_done (commit_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: shadow/active per channel, edge count since reset
  // release, and the commit pending / applying flags.
  int unsigned cyc;
  bit          pending, applying, done_e, epoch_e;
  logic [31:0] sh_f[NCHAN], ac_f[NCHAN], sh_r[NCHAN], ac_r[NCHAN];
  logic [15:0] sh_g[NCHAN], ac_g[NCHAN];
  logic        sh_e[NCHAN], ac_e[NCHAN];
  logic        last_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; pending = 0; applying = 0; done_e = 0; epoch_e = 0;
    for (int i = 0; i < NCHAN; i++) begin
      sh_f[i] = '0; ac_f[i] = '0; sh_r[i] = '0; ac_r[i] = '0;
      sh_g[i] = '0; ac_g[i] = '0; sh_e[i] = 1'b0; ac_e[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit fire, input bit tick, input logic [1:0] ch,
                            input logic [2:0] f, input logic [31:0] d);
    bit was_apply, was_pending;
    was_apply   = applying;
    was_pending = pending;
    epoch_e = tick;
    done_e  = was_apply;
    if (was_apply) begin
      for (int i = 0; i < NCHAN; i++) begin
        ac_f[i] = sh_f[i]; ac_g[i] = sh_g[i]; ac_e[i] = sh_e[i]; ac_r[i] = sh_r[i];
      end
    end
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
    else if (tick && !was_pending) begin
      for (int i = 0; i < NCHAN; i++) if (ac_e[i]) ac_f[i] = ac_f[i] + ac_r[i];
    end
`endif
    applying = was_pending && tick;
    if (was_pending && tick) pending = 0;
    if (fire) begin
      case (f)
        3'd0: sh_f[ch] = d;
        3'd1: sh_g[ch] = d[15:0];
        3'd2: sh_e[ch] = d[0];
`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
        3'd3: sh_r[ch] = d;
`endif
        3'd4: if (!was_pending) pending = 1;
        default: ;
      endcase
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [127:0] ef;
    logic [63:0]  eg;
    logic [3:0]   ee;
    for (int i = 0; i < NCHAN; i++) begin
      ef[i*32 +: 32] = ac_f[i];
      eg[i*16 +: 16] = ac_g[i];
      ee[i]          = ac_e[i];
    end
    chk("chan_freq", chan_freq, ef);
    chk("chan_gain", {64'd0, chan_gain}, {64'd0, eg});
    chk("chan_enable", {124'd0, chan_enable}, {124'd0, ee});
    chk("epoch", {127'd0, epoch}, {127'd0, epoch_e});
    chk("armed", {127'd0, armed}, {127'd0, pending});
    chk("commit_done", {127'd0, commit_done}, {127'd0, done_e});
  endtask

  // One clock cycle: present inputs, check cfg_ready, clock, update model, check.
  task automatic step(input bit v, input logic [1:0] ch, input logic [2:0] f, input logic [31:0] d);
    bit tick, rdy_e;
    cfg_valid = v; cfg_chan = ch; cfg_field = f; cfg_data = d;
    tick  = (cyc % EPOCH_DIV) == (EPOCH_DIV - 1);
    rdy_e = !(applying || (pending && tick));
    #1;
    last_ready = cfg_ready;
    chk("cfg_ready", {127'd0, cfg_ready}, {127'd0, rdy_e});
    @(posedge clk);
    model_edge(v && rdy_e, tick, ch, f, d);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 3'd0, 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_freq", chan_freq, 128'd0);
    chk("rst_gain", {64'd0, chan_gain}, 128'd0);
    chk("rst_enable", {124'd0, chan_enable}, 128'd0);
    chk("rst_epoch", {127'd0, epoch}, 128'd0);
    chk("rst_armed", {127'd0, armed}, 128'd0);
    chk("rst_done", {127'd0, commit_done}, 128'd0);
    chk("rst_ready", {127'd0, cfg_ready}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows;
    bit seen;
    logic [127:0] saved;

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_field = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset_n = 1'b1;

    // Basic apply on channel 2; also covers first epoch after release.
    step(1'b1, 2'd2, 3'd0, 32'h01234567);
    step(1'b1, 2'd2, 3'd1, 32'h00001000);
    step(1'b1, 2'd2, 3'd2, 32'h00000001);
    step(1'b1, 2'd1, 3'd4, 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (commit_done) begin seen = 1; break; end
    end
    chk("basic_done_seen", {127'd0, seen}, 128'd1);
    chk("basic_freq_ch2", {96'd0, chan_freq[95:64]}, {96'd0, 32'h01234567});
    chk("basic_gain_ch2", {112'd0, chan_gain[47:32]}, {112'd0, 16'h1000});
    chk("basic_enable", {124'd0, chan_enable}, {124'd0, 4'b0100});
    idle();
    chk("basic_done_one_pulse", {127'd0, commit_done}, 128'd0);

    // Commit presented on an epoch_tick cycle while idle.
    while ((cyc % EPOCH_DIV) != (EPOCH_DIV - 1)) idle();
    step(1'b1, 2'($urandom_range(0, 3)), 3'd4, $urandom);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      n++;
      if (!armed) break;
    end
    chk("tick_commit_armed_cycles", n, 16);
    repeat (2) idle();

    // Hold freq writes across an ARMED tick; ready must drop for two cycles.
    step(1'b1, 2'd0, 3'd4, 32'h0);
    lows = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 3'd0, $urandom);
      if (!last_ready) lows++;
      if (commit_done) begin seen = 1; break; end
    end
    chk("ready_drop_done_seen", {127'd0, seen}, 128'd1);
    chk("ready_low_cycles", lows, 2);
    saved = chan_freq;
    repeat (3) step(1'b1, 2'($urandom_range(0, 3)), 3'd0, $urandom);
    chk("post_apply_write_shadow_only", chan_freq, saved);

    // Randomized traffic over all fields, including reserved and commit.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), $urandom);
    end
    while (pending || applying) idle();
    repeat (2) idle();

`ifdef SAT_CHAN_SCHED_FREQ_RAMP_EN
    // Doppler ramp with wrap, plus a disabled channel holding its freq.
    step(1'b1, 2'd0, 3'd0, 32'hFFFFFFF0);
    step(1'b1, 2'd0, 3'd3, 32'h00000010);
    step(1'b1, 2'd0, 3'd2, 32'h1);
    step(1'b1, 2'd3, 3'd0, 32'h5A5A0000);
    step(1'b1, 2'd3, 3'd3, 32'h00000007);
    step(1'b1, 2'd3, 3'd2, 32'h0);
    step(1'b1, 2'd0, 3'd4, 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (commit_done) begin seen = 1; break; end
    end
    chk("ramp_done_seen", {127'd0, seen}, 128'd1);
    chk("ramp_apply_freq", {96'd0, chan_freq[31:0]}, {96'd0, 32'hFFFFFFF0});
    do idle(); while (!epoch);
    chk("ramp_wrap_freq", {96'd0, chan_freq[31:0]}, 128'd0);
    do idle(); while (!epoch);
    chk("ramp_third_freq", {96'd0, chan_freq[31:0]}, {96'd0, 32'h00000010});
    chk("ramp_disabled_hold", {96'd0, chan_freq[127:96]}, {96'd0, 32'h5A5A0000});
`else
    // Without the ramp feature a rate write never moves freq.
    step(1'b1, 2'd1, 3'd3, 32'h00000010);
    step(1'b1, 2'd1, 3'd2, 32'h1);
    step(1'b1, 2'd1, 3'd0, $urandom);
    step(1'b1, 2'd1, 3'd4, 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (commit_done) begin seen = 1; break; end
    end
    chk("norampdone_seen", {127'd0, seen}, 128'd1);
    saved = chan_freq;
    for (int e = 0; e < 5; e++) begin
      do idle(); while (!epoch);
      chk("noramp_freq_const", chan_freq, saved);
    end
`endif

    // Reset pulsed while ARMED discards the pending commit.
    repeat (2) idle();
    step(1'b1, 2'd3, 3'd0, 32'hCAFEF00D);
    step(1'b1, 2'd3, 3'd4, 32'h0);
    idle();
    chk("pre_reset_armed", {127'd0, armed}, 128'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (commit_done) n++;
    end
    chk("no_done_after_reset", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
